// File: rtl/simple_wb_master.sv
// ---------------------------------------------------------------------------
// simple_wb_master
//
// Single-outstanding Wishbone classic bus master. One host command (read or
// write) becomes one Wishbone cycle, and exactly one response comes back to
// the host. The attached slaves raise ack and hold it until stb falls, so the
// master drops stb on the same edge it sees ack. It then waits for ack to go
// low again before taking the next command. A bounded counter abandons cycles
// whose slave never answers. A sticky flag records rising edges of the slave
// interrupt line.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cmd_stb/we/adr/dat host command (valid, direction, address, write data)
//   cmd_rdy           master idle; a command is taken when cmd_stb & cmd_rdy
//   rsp_valid         one-cycle response pulse
//   rsp_dat           read data (0 for writes and timeouts)
//   rsp_err           1 = cycle abandoned on timeout
//   wbm_*_o / wbm_*_i Wishbone master signals
//   wbm_int_i         slave interrupt, level
//   int_pending       sticky interrupt flag, cleared by int_clr
// ---------------------------------------------------------------------------
module simple_wb_master #(
   parameter int unsigned TIMEOUT  = 256,
   parameter int unsigned TO_WIDTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_stb,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   output logic        cmd_rdy,
   output logic        rsp_valid,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_int_i,
   output logic        int_pending,
   input  logic        int_clr
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_ACK_LOW = 2'd2;

   localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT - 1);

   logic [1:0]          state_q, state_d;
   logic [TO_WIDTH-1:0] cnt_q, cnt_d;
   logic                cyc_q, cyc_d;
   logic                we_q, we_d;
   logic [31:0]         adr_q, adr_d;
   logic [31:0]         dat_q, dat_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [31:0]         rsp_dat_q, rsp_dat_d;
   logic                int_s_q, int_s_d;
   logic                int_prev_q, int_prev_d;
   logic                int_pend_q, int_pend_d;
   logic                int_set;

   // Bus-cycle sequencing. The counter is shared by REQ (waiting for ack) and
   // ACK_LOW (waiting for a held ack to drop); it is cleared on entry to each.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_dat_d   = rsp_dat_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_stb) begin
               adr_d   = cmd_adr;
               dat_d   = cmd_dat;
               we_d    = cmd_we;
               cyc_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Ack is checked first so it beats a coincident timeout.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
               rsp_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = ST_ACK_LOW;
            end else if (cnt_q == CNT_LAST) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = 32'd0;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ACK_LOW: begin
            // A slave that never releases ack must not wedge the master.
            if (!wbm_ack_i || (cnt_q == CNT_LAST)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cyc_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Interrupt capture: one register stage, then a rising-edge detect on the
   // registered copy. A set on the same edge as a clear wins.
   always_comb begin
      int_s_d    = wbm_int_i;
      int_prev_d = int_s_q;
      int_set    = int_s_q & ~int_prev_q;
      if (int_set) begin
         int_pend_d = 1'b1;
      end else if (int_clr) begin
         int_pend_d = 1'b0;
      end else begin
         int_pend_d = int_pend_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
         int_s_q     <= 1'b0;
         int_prev_q  <= 1'b0;
         int_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
         int_s_q     <= int_s_d;
         int_prev_q  <= int_prev_d;
         int_pend_q  <= int_pend_d;
      end
   end

   // cmd_rdy is gated by rst so the host never sees ready during reset.
   assign cmd_rdy     = (state_q == ST_IDLE) && !rst;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_dat     = rsp_dat_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_we_o    = we_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign int_pending = int_pend_q;

endmodule

// File: tb/tb_simple_wb_master.sv
// ---------------------------------------------------------------------------
// tb_simple_wb_master
//
// Bench for simple_wb_master with TIMEOUT = 8. A behavioural slave acks one
// cycle after it sees stb, holds ack until stb falls (plus a programmable
// number of extra cycles), or never acks at all. Expected responses are
// queued when a command is issued and compared when rsp_valid pulses.
// ---------------------------------------------------------------------------
module tb_simple_wb_master;

   localparam int unsigned TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_stb;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic        cmd_rdy;
   logic        rsp_valid;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        wbm_we_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_int_i;
   logic        int_pending;
   logic        int_clr;

   int vectors    = 0;
   int miscompares = 0;

   logic [32:0] exp_q [$];

   logic [31:0] mem [16];
   logic        never_ack;
   int          extra_hold;
   int          hold_cnt;
   int          hs_cnt;
   logic [31:0] last_wdat;

   simple_wb_master #(.TIMEOUT(TIMEOUT), .TO_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_stb    (cmd_stb),
      .cmd_we     (cmd_we),
      .cmd_adr    (cmd_adr),
      .cmd_dat    (cmd_dat),
      .cmd_rdy    (cmd_rdy),
      .rsp_valid  (rsp_valid),
      .rsp_dat    (rsp_dat),
      .rsp_err    (rsp_err),
      .wbm_we_o   (wbm_we_o),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_adr_o  (wbm_adr_o),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_dat_i  (wbm_dat_i),
      .wbm_ack_i  (wbm_ack_i),
      .wbm_int_i  (wbm_int_i),
      .int_pending(int_pending),
      .int_clr    (int_clr)
   );

   always #5 clk = ~clk;

   // Behavioural slave: registered ack one cycle after stb, held until stb
   // falls plus extra_hold cycles; counts strobe/ack handshakes.
   always @(posedge clk) begin
      if (rst) begin
         wbm_ack_i <= 1'b0;
         hold_cnt  <= 0;
      end else begin
         if (wbm_stb_o && wbm_ack_i) begin
            hs_cnt <= hs_cnt + 1;
            if (wbm_we_o) last_wdat <= wbm_dat_o;
         end
         if (never_ack) begin
            wbm_ack_i <= 1'b0;
         end else if (!wbm_ack_i && wbm_stb_o && wbm_cyc_o) begin
            wbm_ack_i <= 1'b1;
            wbm_dat_i <= mem[wbm_adr_o[3:0]];
            hold_cnt  <= extra_hold;
         end else if (wbm_ack_i && !wbm_stb_o) begin
            if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
            else wbm_ack_i <= 1'b0;
         end
      end
   end

   // Response scoreboard: every rsp_valid cycle pops one expected entry.
   always @(negedge clk) begin
      if (rsp_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_rsp: got err=%0b dat=%h, none expected", rsp_err, rsp_dat);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({rsp_err, rsp_dat} !== e) begin
               miscompares++;
               $display("[TB] FAIL rsp: got err=%0b dat=%h, expected err=%0b dat=%h",
                        rsp_err, rsp_dat, e[32], e[31:0]);
            end
         end
      end
   end

   // Waits for cmd_rdy, presents one command for exactly one accepting edge.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic push, input logic [32:0] exp);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (!cmd_rdy) begin
         miscompares++;
         $display("[TB] FAIL accept_wait: cmd_rdy=%0b after %0d cycles, expected 1", cmd_rdy, n);
         return;
      end
      if (wbm_ack_i !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ack_at_accept: ack=%0b, expected 0", wbm_ack_i);
      end
      if (push) exp_q.push_back(exp);
      cmd_stb = 1'b1;
      cmd_we  = we;
      cmd_adr = adr;
      cmd_dat = dat;
      @(posedge clk);
      #1 cmd_stb = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !cmd_rdy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0 || !cmd_rdy) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d responses outstanding, cmd_rdy=%0b", exp_q.size(), cmd_rdy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({cmd_rdy, wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err, int_pending} !== 7'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: rdy/cyc/stb/we/rv/re/ip=%b, expected 0000000",
                  {cmd_rdy, wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err, int_pending});
      end
      vectors++;
      if ({wbm_adr_o, wbm_dat_o, rsp_dat} !== 96'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: adr=%h dat=%h rsp=%h, expected 0", wbm_adr_o, wbm_dat_o, rsp_dat);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_rdy: cmd_rdy=%0b, expected 1", cmd_rdy);
      end
   endtask

   task automatic test_write();
      int n;
      int hs0;
      hs0 = hs_cnt;
      issue(1'b1, 32'd0, 32'h0000_00FF, 1'b1, {1'b0, 32'd0});
      vectors++;
      if ({wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o} !== {3'b111, 32'd0, 32'h0000_00FF}) begin
         miscompares++;
         $display("[TB] FAIL write_bus: stb=%0b cyc=%0b we=%0b adr=%h dat=%h, expected 1 1 1 0 ff",
                  wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_rdy && n < 50);
      vectors++;
      if (n !== 5) begin
         miscompares++;
         $display("[TB] FAIL write_latency: cmd_rdy back after %0d cycles, expected 5", n);
      end
      wait_drain();
      vectors++;
      if (hs_cnt - hs0 !== 1 || last_wdat !== 32'h0000_00FF) begin
         miscompares++;
         $display("[TB] FAIL write_slave: handshakes=%0d wdat=%h, expected 1 000000ff", hs_cnt - hs0, last_wdat);
      end
   endtask

   task automatic test_read();
      int hs0;
      hs0 = hs_cnt;
      issue(1'b0, 32'd1, 32'h5555_5555, 1'b1, {1'b0, 32'hDEAD_BEEF});
      vectors++;
      if ({wbm_we_o, wbm_adr_o} !== {1'b0, 32'd1}) begin
         miscompares++;
         $display("[TB] FAIL read_bus: we=%0b adr=%h, expected 0 00000001", wbm_we_o, wbm_adr_o);
      end
      wait_drain();
      vectors++;
      if (hs_cnt - hs0 !== 1) begin
         miscompares++;
         $display("[TB] FAIL read_slave: handshakes=%0d, expected 1", hs_cnt - hs0);
      end
   endtask

   task automatic test_timeout();
      int n;
      never_ack = 1'b1;
      issue(1'b0, 32'd2, 32'd0, 1'b1, {1'b1, 32'd0});
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (!wbm_stb_o) break;
         n++;
      end
      vectors++;
      if (n !== TIMEOUT) begin
         miscompares++;
         $display("[TB] FAIL timeout_len: stb high %0d cycles, expected %0d", n, TIMEOUT);
      end
      vectors++;
      if (cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL timeout_rdy: cmd_rdy=%0b, expected 1", cmd_rdy);
      end
      wait_drain();
      never_ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      int hs0;
      hs0 = hs_cnt;
      extra_hold = 3;
      issue(1'b0, 32'd2, 32'd0, 1'b1, {1'b0, 32'h1234_5678});
      issue(1'b0, 32'd3, 32'd0, 1'b1, {1'b0, 32'hCAFE_F00D});
      wait_drain();
      repeat (6) @(negedge clk);
      vectors++;
      if (hs_cnt - hs0 !== 2) begin
         miscompares++;
         $display("[TB] FAIL b2b_slave: handshakes=%0d, expected 2", hs_cnt - hs0);
      end
      extra_hold = 0;
   endtask

   task automatic test_reset_mid();
      never_ack = 1'b1;
      issue(1'b1, 32'd5, 32'h0000_00AA, 1'b0, 33'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, cmd_rdy} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_bus: cyc/stb/we/rv/rdy=%b, expected 00000",
                  {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, cmd_rdy});
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_rdy: cmd_rdy=%0b, expected 1", cmd_rdy);
      end
      repeat (4) @(negedge clk);
      never_ack = 1'b0;
   endtask

   task automatic test_interrupt();
      @(posedge clk);
      #1 wbm_int_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (int_pending !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL int_early: int_pending=%0b, expected 0", int_pending);
      end
      @(negedge clk);
      vectors++;
      if (int_pending !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL int_set: int_pending=%0b, expected 1", int_pending);
      end
      @(posedge clk);
      #1 int_clr = 1'b1;
      @(posedge clk);
      #1 int_clr = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (int_pending !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL int_clr_held: int_pending=%0b, expected 0", int_pending);
      end
      @(posedge clk);
      #1 wbm_int_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 wbm_int_i = 1'b1;
      @(posedge clk);
      #1 int_clr = 1'b1;
      @(posedge clk);
      #1 int_clr = 1'b0;
      @(negedge clk);
      vectors++;
      if (int_pending !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL int_set_vs_clr: int_pending=%0b, expected 1", int_pending);
      end
      wbm_int_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[1]     = 32'hDEAD_BEEF;
      mem[2]     = 32'h1234_5678;
      mem[3]     = 32'hCAFE_F00D;
      rst        = 1'b1;
      cmd_stb    = 1'b0;
      cmd_we     = 1'b0;
      cmd_adr    = '0;
      cmd_dat    = '0;
      wbm_int_i  = 1'b0;
      int_clr    = 1'b0;
      never_ack  = 1'b0;
      extra_hold = 0;
      hs_cnt     = 0;
      last_wdat  = '0;
      wbm_dat_i  = '0;

      $display("[TB] starting simple_wb_master bench");
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_interrupt();
      repeat (3) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL leftover: %0d expected responses never arrived, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/simple_wb_master.md
Name: simple_wb_master

Overview:
- Single-outstanding Wishbone classic bus master: turns one host command (read or write, 32-bit address/data) into one Wishbone cycle and returns one response.
- Drives the bus peripherals' wbs_* slave ports; sits between a host/command decoder and the peripheral bus.
- Follows the slave convention in which a slave raises ack and holds it until stb falls.
- Adds a bounded ack timeout and a sticky interrupt latch for the slave interrupt line.

Parameters:
- TIMEOUT, 256: cycles to wait for ack (or for ack to fall) before abandoning the cycle; legal range 2..65535.
- TO_WIDTH, 16: timeout counter width; must hold TIMEOUT-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_stb  in  1  host command valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  command address
- cmd_dat  in  32  write data
- cmd_rdy  out  1  master idle, command accepted when cmd_stb & cmd_rdy
- rsp_valid  out  1  one-cycle response pulse
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  qualifies rsp_valid, 1 = timeout
- wbm_we_o  out  1  Wishbone write enable
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone ack
- wbm_int_i  in  1  slave interrupt, level
- int_pending  out  1  sticky interrupt flag
- int_clr  in  1  clears int_pending

Behaviour:
- Reset: one clock, synchronous, active-high, per "Already decided". All registered outputs go to 0 on the reset edge, state = IDLE, counter = 0. cmd_rdy is 0 while rst is high and 1 from the first cycle after.
- Reset mid-cycle: cyc/stb drop at the next edge. No response is issued for the aborted command.
- IDLE: cmd_rdy = 1.
  - On cmd_stb at an edge: latch cmd_adr, cmd_dat, cmd_we into wbm_adr_o, wbm_dat_o, wbm_we_o.
  - Set wbm_cyc_o = wbm_stb_o = 1 and clear the counter.
  - Go to REQ. The bus is active on the cycle after acceptance.
- REQ: cmd_rdy = 0; the counter increments each cycle.
  - If wbm_ack_i = 1 at an edge: cyc and stb go to 0 on that same edge, so the slave never sees stb with ack high for a second cycle.
    - For a read, rsp_dat <= wbm_dat_i; for a write, rsp_dat <= 0.
    - rsp_valid = 1 and rsp_err = 0 for exactly one cycle.
    - Clear the counter and go to ACK_LOW.
  - Else, if counter == TIMEOUT-1: cyc/stb <= 0, rsp_valid = 1, rsp_err = 1, rsp_dat = 0; go to IDLE.
  - If ack and the timeout coincide, ack wins.
- ACK_LOW: waits for wbm_ack_i = 0, then goes to IDLE. This prevents a held ack from completing the next command.
  - Counter increments; on TIMEOUT-1 go to IDLE regardless. No further response is issued.
- Ack outside REQ is ignored.
- wbm_adr_o, wbm_dat_o and wbm_we_o hold their values until the next acceptance.
- Nominal latency against a one-cycle-ack slave:
  - acceptance edge E0, stb high E0+1;
  - ack seen at E0+2, rsp_valid high E0+2..E0+3;
  - ack falls by E0+4, cmd_rdy high again E0+4..E0+5.
  - Back-to-back throughput is one command per 5 cycles.
- Interrupt:
  - wbm_int_i is registered once.
  - A rising edge of the registered copy sets int_pending.
  - int_clr clears it.
  - If a set and int_clr occur on the same edge, the set wins.
  - A held-high level does not re-set the flag after a clear.
- rsp_valid and int_pending are independent; both may assert in the same cycle.

Test Plan:
- Write through a slave that acks one cycle after stb and holds ack until stb falls: cmd adr=0, dat=0x0000_00FF, we=1 -> one cycle with wbm_stb_o=1 and wbm_dat_o=0xFF; rsp_valid pulses once with rsp_err=0 and rsp_dat=0; cmd_rdy returns 5 cycles after acceptance.
- Read adr=1 with the slave returning 0xDEAD_BEEF -> rsp_dat = 0xDEADBEEF, rsp_err=0; the slave sees exactly one strobed cycle (no double write/read).
- TIMEOUT=8, slave never acks -> stb high 8 cycles then low; rsp_valid=1, rsp_err=1, rsp_dat=0; cmd_rdy=1 on the next cycle.
- Slave holds ack 3 extra cycles after stb falls, second command presented immediately -> second command is not accepted until ack is 0; its response carries the second read's data.
- rst asserted while in REQ -> cyc/stb/we = 0 at the next edge, no rsp_valid, cmd_rdy=1 the cycle after rst falls.
- wbm_int_i pulses 0->1 and stays high, then int_clr pulsed -> int_pending set 2 cycles after the rise, cleared after int_clr and stays 0 while int stays high; a new rise coincident with int_clr leaves int_pending = 1.
